counter_ctl: RTL and testbench

Parametrised successor to the board LED counter. It runs entirely on one system clock with clock-enable ticks, so no derived clocks are generated. It integrates per-button sync and debounce, and adds a RUN/STEP/HOLD mode FSM, up/down direction and modulo-N wrap with a wrap pulse. It sits between the board buttons and LEDs and drives the count LEDs plus an active-low activity indicator.

---
 rtl/counter_ctl.sv | 167 ++++++++++++++++
 tb/tb_counter_ctl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/counter_ctl.sv
// Button-driven modulo-MOD up/down counter with RUN/STEP/HOLD modes.
// One clock domain: the tick prescaler and the debounce strobe are clock enables.
module counter_ctl #(
  parameter int WIDTH    = 8,
  parameter int MOD      = 256,
  parameter int DIV_BITS = 24,
  parameter int DB_BITS  = 5,
  parameter int DB_LEN   = 4,
  parameter int ACT_W    = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [2:0]       BTTN,
  output logic [WIDTH-1:0] LEDS,
  output logic [ACT_W-1:0] ACT_LED,
  output logic [1:0]       MODE,
  output logic             DIR,
  output logic             WRAP
);

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_STEP = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;

  localparam int               DBC_W    = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_LEN - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  logic [DIV_BITS-1:0]        div_q, div_d;
  logic [DB_BITS-1:0]         strb_q, strb_d;
  logic [2:0]                 sync1_q, sync2_q;
  logic [2:0]                 db_state_q, db_state_d;
  logic [2:0][DBC_W-1:0]      dbcnt_q, dbcnt_d;
  logic [2:0]                 press_q, press_d;
  logic [1:0]                 mode_q, mode_d;
  logic                       dir_q, dir_d;
  logic [WIDTH-1:0]           leds_q, leds_d;
  logic                       wrap_q, wrap_d;
  logic [ACT_W-1:0]           act_q, act_d;
  logic                       tick_s, strobe_s, cnt_evt_s;

  assign tick_s   = &div_q;
  assign strobe_s = &strb_q;

  // Free-running prescaler, debounce strobe counter and activity counter.
  always_comb begin
    div_d  = div_q + DIV_BITS'(1'b1);
    strb_d = strb_q + DB_BITS'(1'b1);
    if (tick_s) begin
      act_d = act_q + ACT_W'(1'b1);
    end else begin
      act_d = act_q;
    end
  end

  // Per-button debounce: a new level is accepted after DB_LEN differing strobes.
  always_comb begin
    db_state_d = db_state_q;
    dbcnt_d    = dbcnt_q;
    press_d    = 3'b000;
    if (strobe_s) begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != db_state_q[i]) begin
          if (dbcnt_q[i] == DBC_LAST) begin
            db_state_d[i] = sync2_q[i];
            dbcnt_d[i]    = {DBC_W{1'b0}};
            press_d[i]    = ~sync2_q[i];
          end else begin
            dbcnt_d[i] = dbcnt_q[i] + DBC_W'(1'b1);
          end
        end else begin
          dbcnt_d[i] = {DBC_W{1'b0}};
        end
      end
    end else begin
      press_d = 3'b000;
    end
  end

  // Mode sequencing and direction toggle; the unused encoding falls back to RUN.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:  if (press_q[1]) mode_d = MODE_STEP; else mode_d = MODE_RUN;
      MODE_STEP: if (press_q[1]) mode_d = MODE_HOLD; else mode_d = MODE_STEP;
      MODE_HOLD: if (press_q[1]) mode_d = MODE_RUN;  else mode_d = MODE_HOLD;
      default:   mode_d = MODE_RUN;
    endcase
    dir_d = dir_q ^ press_q[2];
  end

  // Count event uses pre-edge mode/direction, so same-edge presses apply after it.
  always_comb begin
    case (mode_q)
      MODE_RUN:  cnt_evt_s = tick_s;
      MODE_STEP: cnt_evt_s = press_q[0];
      default:   cnt_evt_s = 1'b0;
    endcase
    leds_d = leds_q;
    wrap_d = 1'b0;
    if (cnt_evt_s) begin
      if (!dir_q) begin
        if (leds_q == CNT_MAX) begin
          leds_d = CNT_ZERO;
          wrap_d = 1'b1;
        end else begin
          leds_d = leds_q + WIDTH'(1'b1);
        end
      end else begin
        if (leds_q == CNT_ZERO) begin
          leds_d = CNT_MAX;
          wrap_d = 1'b1;
        end else begin
          leds_d = leds_q - WIDTH'(1'b1);
        end
      end
    end else begin
      wrap_d = 1'b0;
    end
  end

  // State registers; synchronisers and debounced levels idle high (released).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q      <= {DIV_BITS{1'b0}};
      strb_q     <= {DB_BITS{1'b0}};
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      db_state_q <= 3'b111;
      dbcnt_q    <= {(3 * DBC_W){1'b0}};
      press_q    <= 3'b000;
      mode_q     <= MODE_RUN;
      dir_q      <= 1'b0;
      leds_q     <= CNT_ZERO;
      wrap_q     <= 1'b0;
      act_q      <= {ACT_W{1'b0}};
    end else begin
      div_q      <= div_d;
      strb_q     <= strb_d;
      sync1_q    <= BTTN;
      sync2_q    <= sync1_q;
      db_state_q <= db_state_d;
      dbcnt_q    <= dbcnt_d;
      press_q    <= press_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      leds_q     <= leds_d;
      wrap_q     <= wrap_d;
      act_q      <= act_d;
    end
  end

  // Activity LEDs are active-low and bit-reversed relative to the counter.
  always_comb begin
    ACT_LED = {ACT_W{1'b1}};
    for (int i = 0; i < ACT_W; i++) begin
      ACT_LED[i] = ~act_q[ACT_W-1-i];
    end
  end

  assign LEDS = leds_q;
  assign MODE = mode_q;
  assign DIR  = dir_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_counter_ctl.sv
// Directed bench for counter_ctl with WIDTH=4, MOD=10, DIV_BITS=4, DB_BITS=2, DB_LEN=4.
// Ticks land on clocks 16,32,...; debounce strobes on clocks 4,8,12,... after reset release.
module tb_counter_ctl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] BTTN;
  logic [3:0] LEDS;
  logic [2:0] ACT_LED;
  logic [1:0] MODE;
  logic       DIR;
  logic       WRAP;

  int n_vec  = 0;
  int n_miss = 0;
  int unsigned cyc;

  logic [2:0] act_tab [8] = '{3'b111, 3'b011, 3'b101, 3'b001,
                              3'b110, 3'b010, 3'b100, 3'b000};

  counter_ctl #(
    .WIDTH(4), .MOD(10), .DIV_BITS(4), .DB_BITS(2), .DB_LEN(4), .ACT_W(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTTN(BTTN), .LEDS(LEDS),
    .ACT_LED(ACT_LED), .MODE(MODE), .DIR(DIR), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  // Clocks elapsed since reset release, used to place stimulus and expected activity.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [31:0] exp_act(input int unsigned c);
    return {29'd0, act_tab[(c / 16) % 8]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press_release(input logic [2:0] mask);
    BTTN = BTTN & ~mask;
    step(24);
    BTTN = BTTN | mask;
    step(24);
  endtask

  initial begin
    RST_N = 1'b1;
    BTTN  = 3'b111;
    #2 RST_N = 1'b0;
    step(3);
    check_val("rst_leds", 32'(LEDS), 32'd0);
    check_val("rst_act",  32'(ACT_LED), 32'd7);
    check_val("rst_mode", 32'(MODE), 32'd0);
    check_val("rst_dir",  32'(DIR), 32'd0);
    check_val("rst_wrap", 32'(WRAP), 32'd0);
    RST_N = 1'b1;

    // RUN, up: one increment per 16 clocks
    for (int n = 1; n <= 9; n++) begin
      step(16);
      check_val("run_leds", 32'(LEDS), 32'(n));
      check_val("run_act",  32'(ACT_LED), exp_act(cyc));
      check_val("run_wrap", 32'(WRAP), 32'd0);
    end
    step(4);                       // clock 148: dir press, accepted on strobe 164
    BTTN[2] = 1'b0;
    step(12);                      // clock 160: 9 -> 0
    check_val("wrap_leds", 32'(LEDS), 32'd0);
    check_val("wrap_hi",   32'(WRAP), 32'd1);
    check_val("wrap_act",  32'(ACT_LED), 32'b101);
    check_val("dir_old",   32'(DIR), 32'd0);
    step(1);
    check_val("wrap_lo",   32'(WRAP), 32'd0);
    step(4);                       // clock 165
    check_val("dir_set",   32'(DIR), 32'd1);
    BTTN[2] = 1'b1;
    step(10);                      // clock 175
    check_val("down_pre",  32'(LEDS), 32'd0);
    step(1);                       // clock 176: 0 -> 9
    check_val("down_wrap_leds", 32'(LEDS), 32'd9);
    check_val("down_wrap_hi",   32'(WRAP), 32'd1);
    step(1);
    check_val("down_wrap_lo",   32'(WRAP), 32'd0);
    step(15);                      // clock 192: 9 -> 8
    check_val("down_leds", 32'(LEDS), 32'd8);
    check_val("dir_rel",   32'(DIR), 32'd1);

    // Bouncy mode button: 3 low strobes, 1 high, then held low
    step(1);  BTTN[1] = 1'b0;      // clock 193
    step(12); BTTN[1] = 1'b1;      // clock 205
    step(4);  BTTN[1] = 1'b0;      // clock 209
    step(14);                      // clock 223
    check_val("db_early", 32'(MODE), 32'd0);
    step(1);                       // clock 224
    check_val("db_evt_reg", 32'(MODE), 32'd0);
    check_val("db_leds",    32'(LEDS), 32'd6);
    step(1);                       // clock 225
    check_val("db_mode", 32'(MODE), 32'd1);
    step(40);
    check_val("db_hold_mode", 32'(MODE), 32'd1);
    check_val("step_tick_ign", 32'(LEDS), 32'd6);
    BTTN[1] = 1'b1;
    step(30);
    check_val("db_release", 32'(MODE), 32'd1);

    // STEP mode: direction back to up, then five steps
    press_release(3'b100);
    check_val("step_dir", 32'(DIR), 32'd0);
    check_val("step_dir_leds", 32'(LEDS), 32'd6);
    for (int k = 0; k < 5; k++) begin
      press_release(3'b001);
      check_val("step_leds", 32'(LEDS), 32'((7 + k) % 10));
    end
    // Same-edge presses: count uses the pre-edge direction and mode
    press_release(3'b101);
    check_val("same_dir_leds", 32'(LEDS), 32'd2);
    check_val("same_dir_dir",  32'(DIR), 32'd1);
    press_release(3'b011);
    check_val("same_mode_leds", 32'(LEDS), 32'd1);
    check_val("same_mode_mode", 32'(MODE), 32'd2);

    // HOLD: ticks and steps ignored, activity keeps counting
    step(64);
    check_val("hold_act1", 32'(ACT_LED), exp_act(cyc));
    press_release(3'b001);
    check_val("hold_leds", 32'(LEDS), 32'd1);
    check_val("hold_mode", 32'(MODE), 32'd2);
    check_val("hold_act2", 32'(ACT_LED), exp_act(cyc));
    press_release(3'b010);
    check_val("hold_to_run", 32'(MODE), 32'd0);
    check_val("pre_rst_dir", 32'(DIR), 32'd1);

    // Asynchronous reset mid-cycle with the step button held through release
    @(negedge CLK);
    #2;
    RST_N   = 1'b0;
    BTTN[0] = 1'b0;
    #1;
    check_val("arst_leds", 32'(LEDS), 32'd0);
    check_val("arst_act",  32'(ACT_LED), 32'd7);
    check_val("arst_mode", 32'(MODE), 32'd0);
    check_val("arst_dir",  32'(DIR), 32'd0);
    check_val("arst_wrap", 32'(WRAP), 32'd0);
    step(3);
    RST_N = 1'b1;
    step(16);
    check_val("post_rst_leds", 32'(LEDS), 32'd1);
    check_val("post_rst_act",  32'(ACT_LED), 32'b011);
    step(15);
    check_val("run_step_ign", 32'(LEDS), 32'd1);
    check_val("run_step_mode", 32'(MODE), 32'd0);
    BTTN[0] = 1'b1;
    step(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
